// File: rtl/apb_event_pkg.sv
// Shared constants and types for the APB event-counter sink.
// Default register addresses, FSM state and channel decode enums, status bit map.
package apb_event_pkg;

  localparam logic [31:0] DEF_ADDR_A      = 32'hABBA0000;
  localparam logic [31:0] DEF_ADDR_B      = 32'hBAFF0000;
  localparam logic [31:0] DEF_ADDR_C      = 32'hCAFE0000;
  localparam logic [31:0] DEF_ADDR_STATUS = 32'hC0DE0000;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {CH_A, CH_B, CH_C, CH_NONE} chan_t;

  localparam int STATUS_MISS_A = 0;
  localparam int STATUS_MISS_B = 1;
  localparam int STATUS_MISS_C = 2;

endpackage

// File: rtl/apb_event_chan.sv
// One event channel: last accepted count, +1 continuity check, sticky miss flag
// with write-1-to-clear, and a one-cycle update pulse after each accepted write.
module apb_event_chan (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        clr,
  output logic [31:0] cnt,
  output logic        upd,
  output logic        miss
);

  // A miss raised by a write takes priority over a clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= 32'd0;
      upd  <= 1'b0;
      miss <= 1'b0;
    end else begin
      upd <= wr_en;
      if (wr_en) begin
        cnt <= wr_data;
        if (wr_data != cnt + 32'd1)
          miss <= 1'b1;
      end else if (clr) begin
        miss <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/apb_event_sink.sv
// APB completer terminating the event-counter write stream: decodes three count
// registers plus a status register, inserts wait states, and flags bad accesses.
module apb_event_sink
  import apb_event_pkg::*;
#(
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ADDR_A      = DEF_ADDR_A,
  parameter logic [31:0] ADDR_B      = DEF_ADDR_B,
  parameter logic [31:0] ADDR_C      = DEF_ADDR_C,
  parameter logic [31:0] ADDR_STATUS = DEF_ADDR_STATUS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        apb_psel_i,
  input  logic        apb_penable_i,
  input  logic [31:0] apb_paddr_i,
  input  logic        apb_pwrite_i,
  input  logic [31:0] apb_pwdata_i,
  output logic [31:0] apb_prdata_o,
  output logic        apb_pready_o,
  output logic        apb_pslverr_o,
  output logic [31:0] cnt_a_o,
  output logic [31:0] cnt_b_o,
  output logic [31:0] cnt_c_o,
  output logic [2:0]  upd_o,
  output logic [2:0]  miss_o
);

  state_t      state;
  logic [3:0]  wait_cnt;
  chan_t       chan_q;
  logic        status_q;
  logic        pwrite_q;
  logic [31:0] pwdata_q;

  chan_t       chan_in;
  logic        status_in;
  chan_t       chan_sel;
  logic        status_sel;
  logic        write_sel;
  logic        resp_err;
  logic [31:0] resp_data;

  logic        commit;
  logic [2:0]  wr_en;
  logic [2:0]  clr;

  function automatic chan_t decode_chan(input logic [31:0] addr);
    if (addr == ADDR_A) return CH_A;
    if (addr == ADDR_B) return CH_B;
    if (addr == ADDR_C) return CH_C;
    return CH_NONE;
  endfunction

  assign chan_in   = decode_chan(apb_paddr_i);
  assign status_in = (apb_paddr_i == ADDR_STATUS);

  // With zero wait states the response is registered straight from the setup
  // phase inputs; otherwise it comes from the values latched at setup.
  always_comb begin
    chan_sel   = chan_q;
    status_sel = status_q;
    write_sel  = pwrite_q;
    if (state == IDLE) begin
      chan_sel   = chan_in;
      status_sel = status_in;
      write_sel  = apb_pwrite_i;
    end
  end

  always_comb begin
    resp_err  = 1'b0;
    resp_data = 32'd0;
    if (status_sel) begin
      if (!write_sel)
        resp_data[STATUS_MISS_C:STATUS_MISS_A] = miss_o;
    end else begin
      case (chan_sel)
        CH_A:    if (!write_sel) resp_data = cnt_a_o;
        CH_B:    if (!write_sel) resp_data = cnt_b_o;
        CH_C:    if (!write_sel) resp_data = cnt_c_o;
        default: resp_err = 1'b1;
      endcase
    end
  end

  assign commit   = (state == DONE) && pwrite_q;
  assign wr_en[0] = commit && !status_q && (chan_q == CH_A);
  assign wr_en[1] = commit && !status_q && (chan_q == CH_B);
  assign wr_en[2] = commit && !status_q && (chan_q == CH_C);
  assign clr      = (commit && status_q) ? pwdata_q[STATUS_MISS_C:STATUS_MISS_A] : 3'b000;

  // Transfer FSM; PREADY/PSLVERR/PRDATA are registered and only valid in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= 4'd0;
      chan_q        <= CH_NONE;
      status_q      <= 1'b0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= 32'd0;
      apb_pready_o  <= 1'b0;
      apb_pslverr_o <= 1'b0;
      apb_prdata_o  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (apb_psel_i && !apb_penable_i) begin
            chan_q   <= chan_in;
            status_q <= status_in;
            pwrite_q <= apb_pwrite_i;
            pwdata_q <= apb_pwdata_i;
            wait_cnt <= 4'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              state         <= DONE;
              apb_pready_o  <= 1'b1;
              apb_pslverr_o <= resp_err;
              apb_prdata_o  <= resp_data;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!(apb_psel_i && apb_penable_i)) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
          end else if (wait_cnt <= 4'd1) begin
            state         <= DONE;
            wait_cnt      <= 4'd0;
            apb_pready_o  <= 1'b1;
            apb_pslverr_o <= resp_err;
            apb_prdata_o  <= resp_data;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE: begin
          state         <= IDLE;
          apb_pready_o  <= 1'b0;
          apb_pslverr_o <= 1'b0;
          apb_prdata_o  <= 32'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  apb_event_chan u_chan_a (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en[0]),
    .wr_data (pwdata_q),
    .clr     (clr[0]),
    .cnt     (cnt_a_o),
    .upd     (upd_o[0]),
    .miss    (miss_o[0])
  );

  apb_event_chan u_chan_b (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en[1]),
    .wr_data (pwdata_q),
    .clr     (clr[1]),
    .cnt     (cnt_b_o),
    .upd     (upd_o[1]),
    .miss    (miss_o[1])
  );

  apb_event_chan u_chan_c (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en[2]),
    .wr_data (pwdata_q),
    .clr     (clr[2]),
    .cnt     (cnt_c_o),
    .upd     (upd_o[2]),
    .miss    (miss_o[2])
  );

endmodule
